// File: rtl/cpu_clk_sched_pkg.sv
// Shared definitions for the CPU clock-enable scheduler: FSM state encodings
// and the divider value loaded at reset.
package cpu_clk_sched_pkg;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_DIV = 4'hA;

endpackage

// File: rtl/cpu_clk_sched_edge_det.sv
// Rising-edge detector: rise is high in the cycle where d is 1 and the
// previous registered sample was 0.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/cpu_clk_sched.sv
// CPU clock-enable scheduler: one-cycle cpu_en every (div+1) clocks in RUN,
// stalls on outstanding memory reads with a timeout, supports halt and single-step.
module cpu_clk_sched #(
  parameter int                CNT_W       = 4,
  parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(cpu_clk_sched_pkg::DEFAULT_DIV),
  parameter int                TO_W        = 8,
  parameter logic [TO_W-1:0]   TIMEOUT     = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      step_req,
  input  logic                      div_load,
  input  logic [CNT_W-1:0]          div_value,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  output logic                      cpu_en,
  output logic                      mem_wait,
  output logic                      mem_timeout,
  output logic [31:0]               cpu_cycles,
  output cpu_clk_sched_pkg::state_t dbg_state
);

  import cpu_clk_sched_pkg::*;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   div, div_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic               en_n;
  logic               to_set;
  logic               step_rise;
  logic               stall;

  edge_det u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (step_req),
    .rise (step_rise)
  );

  // A read is still outstanding only if the ack has not arrived alongside it.
  assign stall = mem_req & ~mem_ack;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    to_n    = to_cnt;
    en_n    = 1'b0;
    to_set  = 1'b0;

    if (div_load && state != ST_MEMWAIT) div_n = div_value;

    unique case (state)
      ST_HALT: begin
        cnt_n = '0;
        if (run) begin
          state_n = ST_RUN;
        end else if (step_rise) begin
          if (stall) begin
            state_n = ST_MEMWAIT;
            to_n    = '0;
          end else begin
            en_n = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_n = ST_HALT;
          cnt_n   = '0;
        end else if (div_load) begin
          // Reloading restarts the phase; a coinciding tick is dropped.
          cnt_n = '0;
        end else if (cnt == div) begin
          if (stall) begin
            state_n = ST_MEMWAIT;
            to_n    = '0;
          end else begin
            en_n  = 1'b1;
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ack || to_cnt == TIMEOUT) begin
          en_n    = 1'b1;
          state_n = run ? ST_RUN : ST_HALT;
          cnt_n   = '0;
          to_set  = ~mem_ack;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_HALT;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HALT;
      cnt         <= '0;
      div         <= DEFAULT_DIV;
      to_cnt      <= '0;
      cpu_en      <= 1'b0;
      mem_wait    <= 1'b0;
      mem_timeout <= 1'b0;
      cpu_cycles  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div         <= div_n;
      to_cnt      <= to_n;
      cpu_en      <= en_n;
      mem_wait    <= (state_n == ST_MEMWAIT);
      mem_timeout <= mem_timeout | to_set;
      cpu_cycles  <= cpu_cycles + 32'(en_n);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed testbench for cpu_clk_sched: divider periods, memory stalls,
// timeout, halt/step and divider reload.
module tb_cpu_clk_sched;
  import cpu_clk_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step_req;
  logic        div_load;
  logic [3:0]  div_value;
  logic        mem_req;
  logic        mem_ack;
  logic        cpu_en;
  logic        mem_wait;
  logic        mem_timeout;
  logic [31:0] cpu_cycles;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  cpu_clk_sched #(
    .CNT_W       (4),
    .DEFAULT_DIV (4'hA),
    .TO_W        (8),
    .TIMEOUT     (8'h10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step_req    (step_req),
    .div_load    (div_load),
    .div_value   (div_value),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .cpu_en      (cpu_en),
    .mem_wait    (mem_wait),
    .mem_timeout (mem_timeout),
    .cpu_cycles  (cpu_cycles),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until cpu_en is seen high (bounded by limit).
  task automatic wait_en(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_en && n < limit);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step_req = 1'b0; div_load = 1'b0;
    div_value = 4'd0; mem_req = 1'b0; mem_ack = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic load_div(input logic [3:0] v);
    div_value = v;
    div_load  = 1'b1;
    step(1);
    div_load  = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int doubles;
    logic prev_en;

    rst = 1'b1; run = 1'b0; step_req = 1'b0; div_load = 1'b0;
    div_value = 4'd0; mem_req = 1'b0; mem_ack = 1'b0;
    step(2);
    chk("rst_cpu_en",      cpu_en,      0);
    chk("rst_mem_wait",    mem_wait,    0);
    chk("rst_mem_timeout", mem_timeout, 0);
    chk("rst_cpu_cycles",  cpu_cycles,  0);
    chk("rst_state",       dbg_state,   ST_HALT);
    rst = 1'b0;
    step(1);

    // Async reset mid-run, then the default divider gives an 11-clock period
    load_div(4'd4);
    run = 1'b1;
    wait_en(40, n);
    chk("t1_div4_first", n, 6);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_cpu_en",     cpu_en,      0);
    chk("t1_async_mem_wait",   mem_wait,    0);
    chk("t1_async_cpu_cycles", cpu_cycles,  0);
    chk("t1_async_state",      dbg_state,   ST_HALT);
    @(negedge clk);
    rst = 1'b0;
    wait_en(40, n);
    chk("t1_default_first", n, 12);
    wait_en(40, n);
    chk("t1_default_gap", n, 11);

    // div=3 free-running: pulse every 4 clocks, 10 pulses counted
    apply_reset();
    load_div(4'd3);
    run = 1'b1;
    wait_en(40, n);
    chk("t2_first", n, 5);
    for (int i = 2; i <= 10; i++) begin
      wait_en(40, n);
      chk("t2_gap", n, 4);
    end
    run = 1'b0;
    chk("t2_cycles", cpu_cycles, 10);
    step(10);
    chk("t2_cycles_after_halt", cpu_cycles, 10);
    chk("t2_halt_state", dbg_state, ST_HALT);

    // div=2, read pending at tick, ack 5 clocks later
    apply_reset();
    load_div(4'd2);
    run = 1'b1;
    wait_en(40, n);
    chk("t3_first", n, 4);
    mem_req = 1'b1;
    step(2);
    chk("t3_pre_wait", mem_wait, 0);
    step(1);
    chk("t3_wait_start", mem_wait, 1);
    chk("t3_no_pulse", cpu_en, 0);
    chk("t3_state_memwait", dbg_state, ST_MEMWAIT);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t3_wait_held", mem_wait, 1);
    end
    mem_ack = 1'b1;
    step(1);
    chk("t3_release_en", cpu_en, 1);
    chk("t3_release_wait", mem_wait, 0);
    chk("t3_release_state", dbg_state, ST_RUN);
    chk("t3_cycles", cpu_cycles, 2);
    mem_ack = 1'b0;
    mem_req = 1'b0;
    wait_en(40, n);
    chk("t3_next_gap", n, 3);

    // Ack arriving on the timeout cycle wins: no timeout flag
    apply_reset();
    load_div(4'd2);
    run = 1'b1;
    mem_req = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!mem_wait && n < 20);
    chk("t4a_enter", n, 4);
    step(16);
    chk("t4a_still_waiting", mem_wait, 1);
    mem_ack = 1'b1;
    step(1);
    chk("t4a_release_en", cpu_en, 1);
    chk("t4a_no_timeout", mem_timeout, 0);
    mem_ack = 1'b0;
    mem_req = 1'b0;

    // No ack: forced release after the timeout, run=0 does not abort the wait
    apply_reset();
    load_div(4'd2);
    run = 1'b1;
    mem_req = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!mem_wait && n < 20);
    chk("t4b_enter", n, 4);
    chk("t4b_flag_clear", mem_timeout, 0);
    run = 1'b0;
    n = 0;
    while (mem_wait && n < 100) begin
      n++;
      step(1);
    end
    chk("t4b_wait_cycles", n, 17);
    chk("t4b_release_en", cpu_en, 1);
    chk("t4b_timeout_set", mem_timeout, 1);
    chk("t4b_to_halt", dbg_state, ST_HALT);
    mem_req = 1'b0;
    step(5);
    chk("t4b_timeout_sticky", mem_timeout, 1);
    chk("t4b_quiet", cpu_en, 0);

    // Halted single-step: three held edges give three single pulses
    apply_reset();
    pulses  = 0;
    doubles = 0;
    prev_en = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (cpu_en) pulses++;
        if (cpu_en && prev_en) doubles++;
        prev_en = cpu_en;
      end
      step_req = 1'b0;
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (cpu_en) pulses++;
        if (cpu_en && prev_en) doubles++;
        prev_en = cpu_en;
      end
    end
    chk("t5_pulses", pulses, 3);
    chk("t5_doubles", doubles, 0);
    chk("t5_cycles", cpu_cycles, 3);
    mem_req  = 1'b1;
    step_req = 1'b1;
    step(1);
    chk("t5_step_memwait", mem_wait, 1);
    chk("t5_step_no_pulse", cpu_en, 0);
    mem_ack = 1'b1;
    step(1);
    chk("t5_step_release_en", cpu_en, 1);
    chk("t5_step_back_halt", dbg_state, ST_HALT);
    chk("t5_step_cycles", cpu_cycles, 4);
    mem_ack  = 1'b0;
    mem_req  = 1'b0;
    step_req = 1'b0;

    // Reload to div=0 on the tick: that pulse is dropped, then every cycle
    apply_reset();
    load_div(4'd3);
    run = 1'b1;
    wait_en(40, n);
    chk("t6_first", n, 5);
    step(3);
    div_value = 4'd0;
    div_load  = 1'b1;
    step(1);
    chk("t6_dropped", cpu_en, 0);
    div_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t6_every_cycle", cpu_en, 1);
    end
    chk("t6_cycles", cpu_cycles, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
